// File: rtl/fir_pkg.sv
// Shared FIR datapath constants: widths and Q1.15 clip limits.
// Latency: n/a (constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package fir_pkg;

  // FIR accumulator output is Q3.15; the delivered sample is Q1.15.
  localparam int FIR_OUT_W_IN  = 18;
  localparam int FIR_OUT_W_OUT = 16;
  localparam int FIR_FRAC      = 15;

  localparam logic signed [FIR_OUT_W_OUT-1:0] FIR_Q15_MAX = 16'sh7FFF;
  localparam logic signed [FIR_OUT_W_OUT-1:0] FIR_Q15_MIN = 16'sh8000;

  // Occupancy counter width for a FIFO of the given depth (needs DEPTH+1 codes).
  function automatic int fir_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// Sample-in / sample-out bundle of the FIR decimating output stage.
// Latency: n/a (wiring only).
// Backpressure: o_valid/i_ready handshake on the output side; input side has none.
`timescale 1ns/1ps
interface fir_decim_out_if
  import fir_pkg::*;
#(
  parameter int DEPTH = 4
);

  logic signed [FIR_OUT_W_IN-1:0]  i_y;
  logic                            i_valid;
  logic signed [FIR_OUT_W_OUT-1:0] o_data;
  logic                            o_valid;
  logic                            i_ready;
  logic [fir_level_w(DEPTH)-1:0]   o_level;
  logic                            o_sat;
  logic                            o_ovf;

  // Upstream FIR plus downstream sink.
  modport master (
    output i_y, i_valid, i_ready,
    input  o_data, o_valid, o_level, o_sat, o_ovf
  );

  // The output stage itself.
  modport slave (
    input  i_y, i_valid, i_ready,
    output o_data, o_valid, o_level, o_sat, o_ovf
  );

endinterface

// File: rtl/fir_out_fifo.sv
// Show-ahead FIFO with registered head word, extra-bit pointers and level output.
// Latency: a push into an empty FIFO is visible at the head after the same edge.
// Backpressure: pop on head_vld && ready; a push on full without a pop is dropped and flagged.
`timescale 1ns/1ps
module fir_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     ready,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     head_vld,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE = 1;
  localparam logic [AW-1:0] IDX_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_vld = !empty;
  assign pop      = head_vld && ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign wr_en    = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign level    = wr_ptr - rd_ptr;
  assign rd_nxt   = rd_ptr[AW-1:0] + IDX_ONE;

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + LVL_ONE;
      if (pop)   rd_ptr <= rd_ptr + LVL_ONE;
    end
  end

  // Head register: changes only on a pop or on a push into an empty FIFO, and
  // otherwise holds the last delivered word so the sink never sees stale slots.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      head_dat <= '0;
    end else if (pop) begin
      if (level > LVL_ONE)  head_dat <= mem[rd_nxt];
      else if (wr_en)       head_dat <= push_dat;
    end else if (empty && wr_en) begin
      head_dat <= push_dat;
    end
  end

endmodule

// File: rtl/fir_decim_out.sv
// FIR output stage: Q3.15 -> Q1.15 range reduction, keep 1 of DECIM, buffer in a show-ahead FIFO.
// Latency: 2 cycles from a kept i_valid to o_valid when the FIFO is empty.
// Backpressure: i_ready stalls the FIFO; input cannot stall, so kept samples on a full FIFO are dropped (o_ovf).
// Build option: define FIR_DECIM_OUT_SAT_EN for saturating reduction and a live o_sat; otherwise wrap.
`timescale 1ns/1ps
module fir_decim_out
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            i_rst,
  fir_decim_out_if.slave  bus
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  localparam logic [PH_W-1:0] PH_ONE  = 1;

  logic [PH_W-1:0]                 phase;
  logic                            keep;
  logic signed [FIR_OUT_W_OUT-1:0] red;
  logic                            stg_vld;
  logic signed [FIR_OUT_W_OUT-1:0] stg_dat;
  logic                            drop;
  logic                            ovf;

  // Phase zero on a valid sample marks the one to keep.
  assign keep = bus.i_valid && (phase == '0);

  // Phase counter steps only on valid samples, wrapping after DECIM-1.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)             phase <= '0;
    else if (bus.i_valid)   phase <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
  end

`ifdef FIR_DECIM_OUT_SAT_EN
  localparam logic signed [FIR_OUT_W_IN-1:0] Y_MAX = FIR_Q15_MAX;
  localparam logic signed [FIR_OUT_W_IN-1:0] Y_MIN = FIR_Q15_MIN;

  logic clip;
  logic sat;

  // Saturating reduction: the 15 fractional bits pass through untouched.
  always_comb begin
    red  = bus.i_y[FIR_OUT_W_OUT-1:0];
    clip = 1'b0;
    if (bus.i_y > Y_MAX) begin
      red  = FIR_Q15_MAX;
      clip = 1'b1;
    end else if (bus.i_y < Y_MIN) begin
      red  = FIR_Q15_MIN;
      clip = 1'b1;
    end
  end

  // Sticky clip flag, set on the edge that stages a clipped sample.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)                 sat <= 1'b0;
    else if (keep && clip)      sat <= 1'b1;
  end

  assign bus.o_sat = sat;
`else
  logic unused_hi;

  // Wrapping reduction: the integer guard bits are simply discarded.
  assign red       = bus.i_y[FIR_OUT_W_OUT-1:0];
  assign unused_hi = ^bus.i_y[FIR_OUT_W_IN-1:FIR_OUT_W_OUT];
  assign bus.o_sat = 1'b0;
`endif

  // Stage register between the reduction and the FIFO write port.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      stg_vld <= 1'b0;
      stg_dat <= '0;
    end else begin
      stg_vld <= keep;
      if (keep) stg_dat <= red;
    end
  end

  fir_out_fifo #(
    .WIDTH (FIR_OUT_W_OUT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .i_rst    (i_rst),
    .push     (stg_vld),
    .push_dat (stg_dat),
    .ready    (bus.i_ready),
    .head_dat (bus.o_data),
    .head_vld (bus.o_valid),
    .level    (bus.o_level),
    .drop     (drop)
  );

  // Sticky overflow flag, set on the edge a kept sample is lost.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst)     ovf <= 1'b0;
    else if (drop)  ovf <= 1'b1;
  end

  assign bus.o_ovf = ovf;

endmodule

// File: tb/tb_fir_decim_out.sv
// Directed bench for fir_decim_out: three instances cover DECIM=4, 1 and 3 at DEPTH=4.
// Latency: n/a.
// Backpressure: the sink ready is driven per test.
`timescale 1ns/1ps
module tb_fir_decim_out;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fir_decim_out_if #(.DEPTH(4)) a_if ();
  fir_decim_out_if #(.DEPTH(4)) b_if ();
  fir_decim_out_if #(.DEPTH(4)) c_if ();

  fir_decim_out #(.DECIM(4), .DEPTH(4)) u_a (.clk(clk), .i_rst(rst), .bus(a_if));
  fir_decim_out #(.DECIM(1), .DEPTH(4)) u_b (.clk(clk), .i_rst(rst), .bus(b_if));
  fir_decim_out #(.DECIM(3), .DEPTH(4)) u_c (.clk(clk), .i_rst(rst), .bus(c_if));

  logic signed [15:0] qa[$];
  logic signed [15:0] qb[$];
  logic signed [15:0] qc[$];

`ifdef FIR_DECIM_OUT_SAT_EN
  localparam logic SAT_ON = 1'b1;
`else
  localparam logic SAT_ON = 1'b0;
`endif

  // Record every word the sink takes (popped on the following rising edge).
  always @(negedge clk) begin
    if (a_if.o_valid && a_if.i_ready) qa.push_back(a_if.o_data);
    if (b_if.o_valid && b_if.i_ready) qb.push_back(b_if.o_data);
    if (c_if.o_valid && c_if.i_ready) qc.push_back(c_if.o_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_if.i_valid = 0; a_if.i_y = '0; a_if.i_ready = 0;
    b_if.i_valid = 0; b_if.i_y = '0; b_if.i_ready = 0;
    c_if.i_valid = 0; c_if.i_y = '0; c_if.i_ready = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    qa.delete(); qb.delete(); qc.delete();
  endtask

  task automatic test_reset();
    idle_all();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    n_run++; if (a_if.o_data !== 16'sd0) begin n_fail++; $display("FAIL rst_data: got %0d expected 0", a_if.o_data); end
    n_run++; if (a_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", a_if.o_valid); end
    n_run++; if (a_if.o_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", a_if.o_level); end
    n_run++; if (a_if.o_sat !== 1'b0) begin n_fail++; $display("FAIL rst_sat: got %b expected 0", a_if.o_sat); end
    n_run++; if (a_if.o_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", a_if.o_ovf); end
    rst = 1;
    // Some traffic, then a reset in the middle of the cycle.
    a_if.i_valid = 1; a_if.i_y = 18'sd77;
    repeat (3) tick();
    a_if.i_valid = 0;
    n_run++; if (a_if.o_level !== 3'd1) begin n_fail++; $display("FAIL pre_rst_level: got %0d expected 1", a_if.o_level); end
    #2; rst = 0; #1;
    n_run++; if (a_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", a_if.o_valid); end
    n_run++; if (a_if.o_level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_level: got %0d expected 0", a_if.o_level); end
    #2; rst = 1;
    qa.delete();
  endtask

  task automatic test_ramp();
    int first = -1;
    a_if.i_ready = 1;
    a_if.i_valid = 1;
    for (int k = 0; k < 16; k++) begin
      a_if.i_y = 18'(k);
      tick();
      if (a_if.o_valid && first < 0) first = k;
    end
    a_if.i_valid = 0;
    repeat (4) tick();
    n_run++; if (first !== 1) begin n_fail++; $display("FAIL ramp_latency: got %0d expected 1", first); end
    n_run++;
    if (qa.size() !== 4) begin
      n_fail++; $display("FAIL ramp_count: got %0d expected 4", qa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_run++;
        if (qa[i] !== 16'(4 * i)) begin n_fail++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", i, qa[i], 4 * i); end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [17:0] vin [3];
    logic signed [15:0] vexp [3];
    vin = '{18'sd40000, -18'sd40000, 18'sd1234};
    if (SAT_ON) vexp = '{16'sh7FFF, 16'sh8000, 16'sd1234};
    else        vexp = '{-16'sd25536, 16'sd25536, 16'sd1234};
    do_reset();
    b_if.i_ready = 1;
    for (int i = 0; i < 3; i++) begin
      b_if.i_valid = 1;
      b_if.i_y = vin[i];
      tick();
      if (i == 0) begin
        n_run++; if (b_if.o_sat !== SAT_ON) begin n_fail++; $display("FAIL sat_first: got %b expected %b", b_if.o_sat, SAT_ON); end
      end
    end
    b_if.i_valid = 0;
    repeat (4) tick();
    n_run++;
    if (qb.size() !== 3) begin
      n_fail++; $display("FAIL sat_count: got %0d expected 3", qb.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_run++;
        if (qb[i] !== vexp[i]) begin n_fail++; $display("FAIL sat_data[%0d]: got %0d expected %0d", i, qb[i], vexp[i]); end
      end
    end
    n_run++; if (b_if.o_sat !== SAT_ON) begin n_fail++; $display("FAIL sat_sticky: got %b expected %b", b_if.o_sat, SAT_ON); end
  endtask

  task automatic test_backpressure();
    do_reset();
    b_if.i_ready = 0;
    for (int i = 0; i < 6; i++) begin
      b_if.i_valid = 1;
      b_if.i_y = 18'(10 + i);
      tick();
      if (i == 4) begin
        n_run++; if (b_if.o_level !== 3'd4) begin n_fail++; $display("FAIL bp_full_level: got %0d expected 4", b_if.o_level); end
        n_run++; if (b_if.o_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_early: got %b expected 0", b_if.o_ovf); end
      end
      if (i == 5) begin
        n_run++; if (b_if.o_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_edge: got %b expected 1", b_if.o_ovf); end
      end
    end
    b_if.i_valid = 0;
    tick();
    n_run++; if (b_if.o_level !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d expected 4", b_if.o_level); end
    n_run++; if (b_if.o_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b expected 1", b_if.o_ovf); end
    n_run++; if (b_if.o_data !== 16'sd10) begin n_fail++; $display("FAIL bp_head: got %0d expected 10", b_if.o_data); end
    b_if.i_ready = 1;
    repeat (6) tick();
    n_run++;
    if (qb.size() !== 4) begin
      n_fail++; $display("FAIL bp_count: got %0d expected 4", qb.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_run++;
        if (qb[i] !== 16'(10 + i)) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, qb[i], 10 + i); end
      end
    end
    n_run++; if (b_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b expected 0", b_if.o_valid); end
  endtask

  task automatic test_full_push_pop();
    logic signed [15:0] vexp [5];
    vexp = '{16'sd20, 16'sd21, 16'sd22, 16'sd23, 16'sd99};
    do_reset();
    b_if.i_ready = 0;
    for (int i = 0; i < 4; i++) begin
      b_if.i_valid = 1;
      b_if.i_y = 18'(20 + i);
      tick();
    end
    b_if.i_valid = 0;
    tick();
    n_run++; if (b_if.o_level !== 3'd4) begin n_fail++; $display("FAIL fpp_full: got %0d expected 4", b_if.o_level); end
    b_if.i_valid = 1; b_if.i_y = 18'sd99;
    tick();
    b_if.i_valid = 0;
    n_run++; if (b_if.o_data !== 16'sd20) begin n_fail++; $display("FAIL fpp_head_hold: got %0d expected 20", b_if.o_data); end
    b_if.i_ready = 1;
    tick();
    n_run++; if (b_if.o_level !== 3'd4) begin n_fail++; $display("FAIL fpp_level: got %0d expected 4", b_if.o_level); end
    n_run++; if (b_if.o_ovf !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b expected 0", b_if.o_ovf); end
    n_run++; if (b_if.o_data !== 16'sd21) begin n_fail++; $display("FAIL fpp_head: got %0d expected 21", b_if.o_data); end
    repeat (6) tick();
    n_run++;
    if (qb.size() !== 5) begin
      n_fail++; $display("FAIL fpp_count: got %0d expected 5", qb.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_run++;
        if (qb[i] !== vexp[i]) begin n_fail++; $display("FAIL fpp_data[%0d]: got %0d expected %0d", i, qb[i], vexp[i]); end
      end
    end
  endtask

  task automatic test_gapped();
    do_reset();
    c_if.i_ready = 1;
    for (int s = 1; s <= 9; s++) begin
      c_if.i_valid = 1;
      c_if.i_y = 18'(s);
      tick();
      c_if.i_valid = 0;
      repeat (2) tick();
    end
    repeat (3) tick();
    n_run++;
    if (qc.size() !== 3) begin
      n_fail++; $display("FAIL gap_count: got %0d expected 3", qc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_run++;
        if (qc[i] !== 16'(1 + 3 * i)) begin n_fail++; $display("FAIL gap_data[%0d]: got %0d expected %0d", i, qc[i], 1 + 3 * i); end
      end
    end
  endtask

  task automatic test_reset_burst();
    logic signed [17:0] vin [3];
    int seen;
    vin = '{18'sd40000, 18'sd2, 18'sd3};
    do_reset();
    b_if.i_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b_if.i_valid = 1;
      b_if.i_y = vin[i];
      tick();
    end
    b_if.i_valid = 0;
    tick();
    n_run++; if (b_if.o_level !== 3'd3) begin n_fail++; $display("FAIL rb_level_pre: got %0d expected 3", b_if.o_level); end
    n_run++; if (b_if.o_sat !== SAT_ON) begin n_fail++; $display("FAIL rb_sat_pre: got %b expected %b", b_if.o_sat, SAT_ON); end
    #2; rst = 0; #1;
    n_run++; if (b_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL rb_valid: got %b expected 0", b_if.o_valid); end
    n_run++; if (b_if.o_level !== 3'd0) begin n_fail++; $display("FAIL rb_level: got %0d expected 0", b_if.o_level); end
    n_run++; if (b_if.o_sat !== 1'b0) begin n_fail++; $display("FAIL rb_sat: got %b expected 0", b_if.o_sat); end
    n_run++; if (b_if.o_ovf !== 1'b0) begin n_fail++; $display("FAIL rb_ovf: got %b expected 0", b_if.o_ovf); end
    #2; rst = 1;
    qb.delete();
    b_if.i_ready = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b_if.o_valid) seen++;
    end
    n_run++; if (seen !== 0) begin n_fail++; $display("FAIL rb_stale: got %0d valid cycles expected 0", seen); end
    b_if.i_valid = 1; b_if.i_y = 18'sd5;
    tick();
    b_if.i_valid = 0;
    repeat (4) tick();
    n_run++;
    if (qb.size() !== 1) begin
      n_fail++; $display("FAIL rb_post_count: got %0d expected 1", qb.size());
    end else begin
      n_run++; if (qb[0] !== 16'sd5) begin n_fail++; $display("FAIL rb_post_data: got %0d expected 5", qb[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_full_push_pop();
    test_gapped();
    test_reset_burst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output stage that sits directly downstream of the direct-form FIR and consumes its 18-bit Q3.15 sum. It saturates each sample to 16-bit Q1.15 and keeps one sample in every DECIM. Kept samples are buffered in a small show-ahead FIFO and delivered over a valid/ready interface to the sink (DAC serializer or capture logic). Sticky status flags report saturation and FIFO overflow.

## Interface
- DECIM, 4: decimation factor, 1..16; 1 means pass-through.
- DEPTH, 4: FIFO depth in entries, power of two, 2..16.
- clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_y  in  18  signed FIR output, Q3.15
- i_valid  in  1  i_y holds a new sample this cycle
- o_data  out  16  signed Q1.15 sample at FIFO head
- o_valid  out  1  o_data valid (FIFO not empty)
- i_ready  in  1  sink accepts o_data this cycle
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- o_sat  out  1  sticky: at least one kept sample was clipped
- o_ovf  out  1  sticky: at least one kept sample was dropped on full FIFO

## Operation
- Reset (i_rst low, asynchronous) values:
  - o_data=0, o_valid=0, o_level=0, o_sat=0, o_ovf=0.
  - Phase counter=0, stage register empty, FIFO pointers=0.
  - Mid-operation reset discards all buffered data immediately.
- Phase counter, range 0..DECIM-1:
  - Advances on every i_valid and wraps to 0 after DECIM-1.
  - The sample is kept when the counter equals 0 on that i_valid. Samples 0, DECIM, 2·DECIM, … after reset are kept.
  - With DECIM=1 every sample is kept.
- Stage register: a kept sample is range-reduced and registered together with a stage-valid bit.
- Range reduction (see Configuration):
  - Clip range for Q3.15→Q1.15 is +32767 (16'h7FFF) and −32768 (16'h8000).
  - No rounding; the 15 fractional bits are preserved.
- FIFO push: stage-valid pushes the stage register into the FIFO.
- FIFO pop: o_valid && i_ready.
- Full FIFO:
  - Push with no pop: the sample is dropped, o_ovf is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both proceed and o_level is unchanged.
- Empty FIFO: i_ready is ignored. o_data holds its last value while o_valid=0.
- o_sat and o_ovf clear only on reset.

## Timing
- Latency, empty FIFO:
  - i_valid with a kept sample at edge n.
  - Stage register loaded at edge n.
  - FIFO written at edge n+1.
  - o_valid=1 and o_data valid after edge n+1, so latency is 2 cycles.
- o_level updates on the same edge as the push or pop.
- Throughput: one kept sample per cycle at DECIM=1. Full rate is sustained while i_ready stays high.
- o_data/o_valid may change only on a pop or on a push into an empty FIFO. The head is stable while o_valid && !i_ready.
- o_sat sets on the edge that loads the clipped sample into the stage register.
- o_ovf sets on the edge the drop occurs.

## Configuration
- FIR_DECIM_OUT_SAT_EN defined:
  - Saturating range reduction: i_y>32767 gives 32767; i_y<−32768 gives −32768; otherwise i_y[15:0].
  - o_sat is operational.
- FIR_DECIM_OUT_SAT_EN undefined:
  - Wrapping truncation, o_data = i_y[15:0].
  - o_sat is tied 0 and no comparators are built.

## Structure
- Shared package fir_pkg holds:
  - FIR_OUT_W_IN=18, FIR_OUT_W_OUT=16, FIR_FRAC=15.
  - Q1.15 limits FIR_Q15_MAX=16'sh7FFF and FIR_Q15_MIN=16'sh8000.
- Sub-module fir_out_fifo contains:
  - Parameterized show-ahead FIFO (WIDTH, DEPTH).
  - Extra-bit read/write pointers, full/empty and level generation.
- The top level holds the phase counter, range reduction, stage register and sticky flags.

## Test plan
- Reset and ramp, DECIM=4: reset mid-stream, then i_y=0,1,2,…,15 with i_valid held high and i_ready=1 → o_data sequence 0,4,8,12, first o_valid 2 cycles after the first i_valid; all outputs 0 during reset.
- Saturation with macro on, DECIM=1: i_y=40000, −40000, 1234 → o_data 32767, −32768, 1234; o_sat=1 after the first sample. Macro off → o_data −25536, 25536, 1234; o_sat=0.
- Backpressure, DECIM=1, DEPTH=4: i_ready=0 while 6 samples 10..15 arrive → o_level=4, o_ovf=1. Then i_ready=1 → o_data 10,11,12,13, then o_valid=0.
- Full with simultaneous push and pop: FIFO full, i_ready=1, new sample 99 → no drop, o_level stays 4, o_ovf stays 0, and 99 is delivered in order.
- Gapped input, DECIM=3: i_valid pulses every 3rd cycle carrying samples 1..9 → output 1,4,7; phase counter advances only on i_valid.
- Reset during a burst: assert i_rst low while o_level=3 → o_valid, o_level and the sticky flags drop to 0 asynchronously, and no stale data appears after release.
